// File: rtl/reg_access_pkg.sv
// Shared register-access definitions: default bus geometry, command opcodes, arbiter states.
// Pure declarations; no logic, no latency, no backpressure.
package reg_access_pkg;

    localparam int WORD_WIDTH_DEF  = 8;
    localparam int VALUE_WORDS_DEF = 4;

    localparam logic [7:0] CMD_WRITE = 8'h77;
    localparam logic [7:0] CMD_READ  = 8'h72;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side bundle of the register bank arbiter: packed per-requester requests, shared read data.
// Requesters hold i_req until their o_ack pulse; the arbiter drives the o_* side.
interface reg_bank_arbiter_if
    import reg_access_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int WORD_WIDTH  = WORD_WIDTH_DEF,
    parameter int VALUE_WORDS = VALUE_WORDS_DEF
);
    localparam int DW = WORD_WIDTH * VALUE_WORDS;

    logic [N_REQ-1:0]            i_req;
    logic [N_REQ-1:0]            i_we;
    logic [N_REQ*WORD_WIDTH-1:0] i_addr;
    logic [N_REQ*DW-1:0]         i_wdata;
    logic [N_REQ-1:0]            o_ack;
    logic [N_REQ-1:0]            o_rvalid;
    logic [DW-1:0]               o_rdata;

    modport master (
        output i_req, i_we, i_addr, i_wdata,
        input  o_ack, o_rvalid, o_rdata
    );

    modport slave (
        input  i_req, i_we, i_addr, i_wdata,
        output o_ack, o_rvalid, o_rdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin winner select: combinational grant from req and ptr; ptr moves past the winner on advance.
// Grant is zero-latency; no backpressure, the caller decides when to advance.
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    input  logic [IW-1:0]    adv_idx,
    output logic [IW-1:0]    grant,
    output logic             any_req
);

    logic [IW-1:0] ptr;

    // Walk offsets from highest to lowest so the requester nearest ptr overrides the rest.
    always_comb begin
        logic [IW:0] idx;
        idx     = '0;
        grant   = ptr;
        any_req = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(N_REQ)) begin
                idx = idx - (IW+1)'(N_REQ);
            end
            if (req[idx[IW-1:0]]) begin
                grant = idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (adv_idx == IW'(N_REQ - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares one single-port register bank among N_REQ requesters, one transaction at a time, round-robin.
// Write: strobe +1, ack +2; read: strobe +1, ack/rvalid +3; requesters simply hold i_req until acked.
module reg_bank_arbiter
    import reg_access_pkg::*;
#(
    parameter  int WORD_WIDTH  = WORD_WIDTH_DEF,
    parameter  int VALUE_WORDS = VALUE_WORDS_DEF,
    parameter  int N_REQ       = 2,
    localparam int DW          = WORD_WIDTH * VALUE_WORDS,
    localparam int IW          = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  i_reset,
    reg_bank_arbiter_if.slave     req_bus,
    output logic                  o_bank_w_en,
    output logic                  o_bank_r_en,
    output logic [WORD_WIDTH-1:0] o_bank_addr,
    output logic [DW-1:0]         o_bank_wdata,
    input  logic [DW-1:0]         i_bank_rdata
);

    arb_state_t       state;
    logic [IW-1:0]    g_q;
    logic             we_q;
    logic [N_REQ-1:0] ack_q;
    logic [N_REQ-1:0] rvalid_q;
    logic [DW-1:0]    rdata_q;
    logic [IW-1:0]    grant;
    logic             any_req;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk     (clk),
        .i_reset (i_reset),
        .req     (req_bus.i_req),
        .advance (state == RESP),
        .adv_idx (g_q),
        .grant   (grant),
        .any_req (any_req)
    );

    assign req_bus.o_ack    = ack_q;
    assign req_bus.o_rvalid = rvalid_q;
    assign req_bus.o_rdata  = rdata_q;

    // The bank address/value registers double as the latched request, so they hold between transactions.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state        <= IDLE;
            g_q          <= '0;
            we_q         <= 1'b0;
            ack_q        <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            o_bank_w_en  <= 1'b0;
            o_bank_r_en  <= 1'b0;
            o_bank_addr  <= '0;
            o_bank_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        g_q          <= grant;
                        we_q         <= req_bus.i_we[grant];
                        o_bank_addr  <= req_bus.i_addr[int'(grant)*WORD_WIDTH +: WORD_WIDTH];
                        o_bank_wdata <= req_bus.i_wdata[int'(grant)*DW +: DW];
                        o_bank_w_en  <= req_bus.i_we[grant];
                        o_bank_r_en  <= !req_bus.i_we[grant];
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_bank_w_en <= 1'b0;
                    o_bank_r_en <= 1'b0;
                    if (we_q) begin
                        ack_q <= N_REQ'(1) << g_q;
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rdata_q  <= i_bank_rdata;
                    ack_q    <= N_REQ'(1) << g_q;
                    rvalid_q <= N_REQ'(1) << g_q;
                    state    <= RESP;
                end
                RESP: begin
                    ack_q    <= '0;
                    rvalid_q <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter (N_REQ=2 and N_REQ=4 instances) with a transaction-timeline model.
module tb_reg_bank_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_bank_arbiter_if #(.N_REQ(2), .WORD_WIDTH(8), .VALUE_WORDS(4)) b2 ();
    reg_bank_arbiter_if #(.N_REQ(4), .WORD_WIDTH(8), .VALUE_WORDS(4)) b4 ();

    logic        w2, r2, w4, r4;
    logic [7:0]  a2, a4;
    logic [31:0] wd2, wd4, rd2, rd4;

    reg_bank_arbiter #(.WORD_WIDTH(8), .VALUE_WORDS(4), .N_REQ(2)) dut2 (
        .clk(clk), .i_reset(rst), .req_bus(b2.slave),
        .o_bank_w_en(w2), .o_bank_r_en(r2), .o_bank_addr(a2),
        .o_bank_wdata(wd2), .i_bank_rdata(rd2));

    reg_bank_arbiter #(.WORD_WIDTH(8), .VALUE_WORDS(4), .N_REQ(4)) dut4 (
        .clk(clk), .i_reset(rst), .req_bus(b4.slave),
        .o_bank_w_en(w4), .o_bank_r_en(r4), .o_bank_addr(a4),
        .o_bank_wdata(wd4), .i_bank_rdata(rd4));

    // Bank: fixed contents, read data registered one cycle after the read strobe.
    function automatic logic [31:0] bank_val(input logic [7:0] a);
        return (a == 8'h05) ? 32'hCAFEF00D : ({4{a}} ^ 32'h5A5A5A5A);
    endfunction

    always @(posedge clk) begin
        if (r2) rd2 <= bank_val(a2);
        if (r4) rd4 <= bank_val(a4);
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: per DUT, a transaction granted at edge t0 shows its strobe after t0,
    // its ack after t0+1 (write) or t0+2 (read), and frees the arbiter at the edge after that.
    bit          m_init[2], m_act[2], m_we[2];
    int          m_t0[2], m_g[2], m_ptr[2];
    logic [7:0]  m_addr[2];
    logic [31:0] m_wd[2];
    logic        e_wen[2], e_ren[2];
    logic [7:0]  e_ba[2];
    logic [31:0] e_bwd[2], e_rd[2];
    logic [3:0]  e_ack[2], e_rv[2];
    logic [3:0]  in_req[2], in_we[2];
    logic [7:0]  in_a[2][4];
    logic [31:0] in_wd[2][4];

    always @(posedge clk) begin
        cyc++;
        in_req[0] = '0;
        in_we[0]  = '0;
        for (int k = 0; k < 2; k++) begin
            in_req[0][k] = b2.i_req[k];
            in_we[0][k]  = b2.i_we[k];
            in_a[0][k]   = b2.i_addr[k*8 +: 8];
            in_wd[0][k]  = b2.i_wdata[k*32 +: 32];
        end
        for (int k = 0; k < 4; k++) begin
            in_req[1][k] = b4.i_req[k];
            in_we[1][k]  = b4.i_we[k];
            in_a[1][k]   = b4.i_addr[k*8 +: 8];
            in_wd[1][k]  = b4.i_wdata[k*32 +: 32];
        end
        for (int d = 0; d < 2; d++) begin
            int n;
            int lat;
            n = (d == 0) ? 2 : 4;
            if (rst) begin
                m_init[d] = 1'b1; m_act[d] = 1'b0; m_ptr[d] = 0;
                e_wen[d] = 1'b0; e_ren[d] = 1'b0; e_ba[d] = '0; e_bwd[d] = '0;
                e_ack[d] = '0; e_rv[d] = '0; e_rd[d] = '0;
            end else if (m_init[d]) begin
                e_wen[d] = 1'b0; e_ren[d] = 1'b0; e_ack[d] = '0; e_rv[d] = '0;
                if (m_act[d]) begin
                    lat = m_we[d] ? 1 : 2;
                    if (cyc == m_t0[d] + lat) begin
                        e_ack[d][m_g[d]] = 1'b1;
                        if (!m_we[d]) begin
                            e_rv[d][m_g[d]] = 1'b1;
                            e_rd[d] = bank_val(m_addr[d]);
                        end
                    end
                    if (cyc == m_t0[d] + lat + 1) begin
                        m_act[d] = 1'b0;
                        m_ptr[d] = (m_g[d] + 1) % n;
                    end
                end else begin
                    for (int i = 0; i < n; i++) begin
                        int k;
                        k = (m_ptr[d] + i) % n;
                        if (!m_act[d] && in_req[d][k]) begin
                            m_act[d] = 1'b1; m_g[d] = k; m_t0[d] = cyc;
                            m_we[d] = in_we[d][k]; m_addr[d] = in_a[d][k]; m_wd[d] = in_wd[d][k];
                        end
                    end
                    if (m_act[d]) begin
                        e_wen[d] = m_we[d]; e_ren[d] = !m_we[d];
                        e_ba[d] = m_addr[d]; e_bwd[d] = m_wd[d];
                    end
                end
            end
        end
        #1;
        if (m_init[0])
            chk("dut2_outputs", 128'({w2, r2, a2, wd2, 2'b00, b2.o_ack, 2'b00, b2.o_rvalid, b2.o_rdata}),
                128'({e_wen[0], e_ren[0], e_ba[0], e_bwd[0], e_ack[0], e_rv[0], e_rd[0]}));
        if (m_init[1])
            chk("dut4_outputs", 128'({w4, r4, a4, wd4, b4.o_ack, b4.o_rvalid, b4.o_rdata}),
                128'({e_wen[1], e_ren[1], e_ba[1], e_bwd[1], e_ack[1], e_rv[1], e_rd[1]}));
    end

    task automatic wait_ack2(output logic [1:0] a);
        a = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b2.o_ack != 2'b00) begin
                a = b2.o_ack;
                break;
            end
        end
    endtask

    initial begin
        logic [1:0] a;
        int wa[$];
        int wc[$];
        int nack;
        b2.i_req = '0; b2.i_we = '0; b2.i_addr = '0; b2.i_wdata = '0;
        b4.i_req = '0; b4.i_we = '0; b4.i_addr = '0; b4.i_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_wen", 128'(w2), 128'(0));
        chk("reset_ack", 128'(b2.o_ack), 128'(0));
        chk("reset_rdata", 128'(b2.o_rdata), 128'(0));
        chk("reset_ack4", 128'(b4.o_ack), 128'(0));
        rst = 1'b0;

        // 1: write from requester 0
        b2.i_req[0] = 1'b1; b2.i_we[0] = 1'b1;
        b2.i_addr[7:0] = 8'h05; b2.i_wdata[31:0] = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_wen", 128'(w2), 128'(1));
        chk("t1_addr", 128'(a2), 128'(8'h05));
        chk("t1_wdata", 128'(wd2), 128'(32'hDEADBEEF));
        chk("t1_ack_early", 128'(b2.o_ack), 128'(0));
        @(negedge clk);
        chk("t1_ack", 128'(b2.o_ack), 128'(2'b01));
        chk("t1_rvalid", 128'(b2.o_rvalid), 128'(0));
        chk("t1_wen_off", 128'(w2), 128'(0));
        b2.i_req[0] = 1'b0;
        @(negedge clk);
        chk("t1_ack_clear", 128'(b2.o_ack), 128'(0));

        // 2: read from requester 1, then a write must not disturb o_rdata
        b2.i_req[1] = 1'b1; b2.i_we[1] = 1'b0; b2.i_addr[15:8] = 8'h05;
        @(negedge clk);
        chk("t2_ren", 128'(r2), 128'(1));
        chk("t2_addr", 128'(a2), 128'(8'h05));
        @(negedge clk);
        chk("t2_ack_wait", 128'(b2.o_ack), 128'(0));
        @(negedge clk);
        chk("t2_ack", 128'(b2.o_ack), 128'(2'b10));
        chk("t2_rvalid", 128'(b2.o_rvalid), 128'(2'b10));
        chk("t2_rdata", 128'(b2.o_rdata), 128'(32'hCAFEF00D));
        b2.i_req[1] = 1'b0;
        @(negedge clk);
        b2.i_req[0] = 1'b1; b2.i_addr[7:0] = 8'h07; b2.i_wdata[31:0] = 32'h11223344;
        repeat (2) @(negedge clk);
        chk("t2_wr_ack", 128'(b2.o_ack), 128'(2'b01));
        b2.i_req[0] = 1'b0;
        @(negedge clk);
        chk("t2_rdata_hold", 128'(b2.o_rdata), 128'(32'hCAFEF00D));

        // 3: both requesting from reset -> 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b2.i_we = 2'b11; b2.i_addr = 16'h2120; b2.i_req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_ack2(a);
            chk($sformatf("t3_grant%0d", j), 128'(a), 128'((j % 2 == 0) ? 2'b01 : 2'b10));
        end
        b2.i_req = 2'b00;
        @(negedge clk);

        // 4: req1 alone, then both -> pointer wraps to 0, then 1
        b2.i_addr[15:8] = 8'h30; b2.i_req[1] = 1'b1;
        wait_ack2(a);
        chk("t4_first", 128'(a), 128'(2'b10));
        b2.i_req[1] = 1'b0;
        @(negedge clk);
        b2.i_req = 2'b11;
        wait_ack2(a);
        chk("t4_wrap", 128'(a), 128'(2'b01));
        b2.i_req[0] = 1'b0;
        wait_ack2(a);
        chk("t4_next", 128'(a), 128'(2'b10));
        b2.i_req[1] = 1'b0;
        @(negedge clk);

        // 5: reset during WAIT aborts the read; a fresh read then completes in 3 cycles
        b2.i_we[0] = 1'b0; b2.i_addr[7:0] = 8'h09; b2.i_req[0] = 1'b1;
        @(negedge clk);
        chk("t5_ren", 128'(r2), 128'(1));
        @(negedge clk);
        rst = 1'b1; b2.i_req[0] = 1'b0;
        @(negedge clk);
        chk("t5_no_ack", 128'(b2.o_ack), 128'(0));
        chk("t5_no_rvalid", 128'(b2.o_rvalid), 128'(0));
        chk("t5_strobes", 128'({w2, r2}), 128'(0));
        rst = 1'b0; b2.i_req[0] = 1'b1;
        @(negedge clk);
        chk("t5_ren2", 128'(r2), 128'(1));
        repeat (2) @(negedge clk);
        chk("t5_ack", 128'(b2.o_ack), 128'(2'b01));
        chk("t5_rvalid", 128'(b2.o_rvalid), 128'(2'b01));
        chk("t5_rdata", 128'(b2.o_rdata), 128'(32'h53535353));
        b2.i_req[0] = 1'b0;
        @(negedge clk);

        // 6: four requesters on the N_REQ=4 instance
        b4.i_we = 4'hF;
        for (int k = 0; k < 4; k++) begin
            b4.i_addr[k*8 +: 8]   = 8'(8'h10 + k);
            b4.i_wdata[k*32 +: 32] = 32'hA0000000 + 32'(k);
        end
        b4.i_req = 4'hF;
        nack = 0;
        for (int i = 0; i < 60 && nack < 4; i++) begin
            @(negedge clk);
            if (w4) begin
                wa.push_back(int'(a4));
                wc.push_back(cyc);
            end
            for (int k = 0; k < 4; k++) begin
                if (b4.o_ack[k]) begin
                    b4.i_req[k] = 1'b0;
                    nack++;
                end
            end
        end
        chk("t6_nwrites", 128'(wa.size()), 128'(4));
        for (int j = 0; j < wa.size(); j++) begin
            chk($sformatf("t6_addr%0d", j), 128'(wa[j]), 128'(16 + j));
            if (j > 0) chk($sformatf("t6_gap%0d", j), 128'(wc[j] - wc[j-1]), 128'(3));
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares one single-port register bank between N_REQ independent requesters, for example the UART command path and an on-chip status/debug master.
- Grants requests round-robin, one transaction at a time.
- Drives the bank's write/read strobes, address and value, and returns the acknowledge and read data to the granted requester.
- Sits between the command decoders and the register bank.

Parameters:
- WORD_WIDTH, 8: address width in bits; also the word size of the value.
- VALUE_WORDS, 4: value width in words; DW = WORD_WIDTH*VALUE_WORDS.
- N_REQ, 2: number of requesters, 2..8; IW = $clog2(N_REQ).

Ports:
- clk  in  1  clock.
- i_reset  in  1  synchronous reset, active-high.
- i_req  in  N_REQ  per-requester request level; held until o_ack.
- i_we  in  N_REQ  per-requester 1=write, 0=read; valid while i_req.
- i_addr  in  N_REQ*WORD_WIDTH  packed addresses; requester k at [k*WORD_WIDTH +: WORD_WIDTH].
- i_wdata  in  N_REQ*DW  packed write values; requester k at [k*DW +: DW].
- o_ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- o_rvalid  out  N_REQ  qualifies o_rdata; pulses with o_ack, reads only.
- o_rdata  out  DW  read value, shared by all requesters.
- o_bank_w_en  out  1  bank write strobe.
- o_bank_r_en  out  1  bank read strobe.
- o_bank_addr  out  WORD_WIDTH  bank address.
- o_bank_wdata  out  DW  bank write value.
- i_bank_rdata  in  DW  bank read data, valid the cycle after o_bank_r_en.

Behaviour:
- All outputs are registered or decoded from registered state; there is no combinational path from i_* to o_*.
- Reset values: state IDLE, all o_* 0, RR pointer 0. Reset applied mid-transaction aborts it: no o_ack is issued, strobes are 0 the cycle after reset is sampled, and the requester must re-request.
- State machine: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any i_req bit is set, select winner g = first set bit searching from ptr upward, with wrap.
  - Latch g, i_we[g], i_addr[g] and i_wdata[g]; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - Drive o_bank_addr/o_bank_wdata from latched values.
  - Assert o_bank_w_en if write, o_bank_r_en if read; never both.
  - Write goes to RESP; read goes to WAIT.
- WAIT (1 cycle): capture i_bank_rdata into o_rdata at the end of the cycle; go to RESP.
- RESP (1 cycle):
  - Assert o_ack[g]; also assert o_rvalid[g] if read.
  - Set ptr <= (g+1) mod N_REQ; go to IDLE.
- o_rdata holds its last read value until the next read capture; writes do not change it.
- o_bank_addr/o_bank_wdata hold their last values outside ISSUE; only the strobes qualify them.
- Latency, counted from the IDLE cycle in which i_req is sampled:
  - Write: strobe at +1, ack at +2.
  - Read: strobe at +1, ack/rvalid at +3.
  - Back-to-back throughput: one write per 3 cycles, one read per 4 cycles.
- Requester rules:
  - i_req, i_we, i_addr and i_wdata must be stable from assertion until the o_ack cycle.
  - i_req must drop by the cycle after o_ack. If i_req is still high in the IDLE cycle following ack, it is a new request.
  - Changes to inputs of a non-granted requester during a transaction have no effect.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N_REQ-1,0. A requester waits at most N_REQ-1 transactions.
- Simultaneous events: a request arriving during ISSUE/WAIT/RESP is considered only at the next IDLE. Ack and a new grant never share a cycle.
- Requests are not checked for address range; the bank decodes addresses.

Decomposition:
- Package reg_access_pkg:
  - Default WORD_WIDTH/VALUE_WORDS.
  - CMD_WRITE = 8'h77 and CMD_READ = 8'h72, shared with the command decoders.
  - Enum arb_state_t {IDLE, ISSUE, WAIT, RESP}.
- Sub-module rr_arbiter #(N_REQ):
  - Combinational winner select from i_req and ptr, outputting grant index and any_req.
  - Pointer register updated on an advance strobe.
  - Sync reset to 0.
  - Reusable elsewhere.

Test Plan:
1. Reset, then req0 write addr=0x05 value=0xDEADBEEF -> o_bank_w_en one cycle with addr 0x05 / wdata 0xDEADBEEF at +1; o_ack[0] at +2; o_rvalid=0.
2. Bank model returns 0xCAFEF00D for addr 0x05; req1 read addr=0x05 -> o_bank_r_en at +1; o_ack[1]=o_rvalid[1]=1 with o_rdata=0xCAFEF00D at +3; o_rdata unchanged by a later write.
3. req0 and req1 asserted together from reset and held (re-asserted after each ack) -> grant order 0,1,0,1 over 4 transactions; no requester is acked twice consecutively.
4. Request first granted to req1, then both request -> req0 granted next (pointer wrap); then req1.
5. i_reset asserted during WAIT of a read -> no o_ack/o_rvalid; all strobes 0 the next cycle; a fresh req0 read after reset completes in 3 cycles.
6. N_REQ=4 instance, all four requesting writes to addrs 0x10..0x13 -> bank sees writes in order 0x10,0x11,0x12,0x13, each 3 cycles apart.
